time_field_counter: RTL and testbench
=====================================

Name: time_field_counter

Overview:
Generalised clock-field register for the digital clock: one instance each for seconds, minutes and hours, chained by carry. Holds a modulo-MODULUS value. The value is set from switches only after they settle, is advanced by a timebase tick, and can be stepped up or down by pushbuttons. It drives its own LED bank and emits a carry pulse to the next field on wrap.

Parameters:
WIDTH, 6, bit width of sw/value/led
MODULUS, 60, count range 0..MODULUS-1 (60 for sec/min, 24 for hours); legal 2..2**WIDTH, elaboration error otherwise
SETTLE_CYCLES, 1000, consecutive clk edges sw must hold a new value before it is loaded; legal >=1

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
tick  input  1  one-cycle advance pulse from timebase or carry of previous field
hold  input  1  1 = ignore tick (buttons and switch load still act)
sw  input  WIDTH  switch set value, asynchronous to nothing (already synchronised upstream)
btn_up  input  1  debounced level; rising edge = +1
btn_dn  input  1  debounced level; rising edge = -1
value  output  WIDTH  current field value, registered
led  output  WIDTH  equals value, combinational copy
carry  output  1  registered one-cycle pulse, wrap via tick
load_done  output  1  registered one-cycle pulse, switch load occurred

Behaviour:
- Reset (async assert, sync-safe release): value=0, carry=0, load_done=0, candidate register cand=0, settle counter=0, armed=0, button history regs=0.
- Switch settle, per edge:
  - sw!=cand: cand<=sw, cnt<=0, armed<=1 (this is edge 0).
  - else if armed: if cnt==SETTLE_CYCLES-1, perform load, armed<=0; else cnt<=cnt+1.
  - Net latency: new value appears at edge SETTLE_CYCLES after edge 0. Any sw change inside the window restarts it from the new value.
- Load: value<=min(cand, MODULUS-1) (saturating clamp, no wrap). load_done=1 for exactly the cycle in which the new value is first visible.
- Buttons: rising edge = level high now, low on previous edge (history reg). One step per press; held button does not repeat.
  - up: MODULUS-1 -> 0, else +1.
  - dn: 0 -> MODULUS-1, else -1.
  - Buttons never assert carry.
  - up and dn edges on the same edge: no change.
- Tick (hold=0): MODULUS-1 -> 0 with carry=1 on the next cycle only, else +1 with carry=0. Tick while hold=1 is discarded and not remembered.
- Per-edge priority: load > button step > tick. A lower-priority event on the same edge is dropped, not deferred; its carry is suppressed too.
- carry and load_done default 0 every cycle they are not asserted; never high two consecutive cycles from a single event.
- Arithmetic uses a WIDTH-bit value; the compare against MODULUS-1 is done before increment so no overflow for MODULUS=2**WIDTH.
- Reset mid-settle: pending load abandoned. If sw!=0 after release, it is treated as a fresh change and loads SETTLE_CYCLES edges later.
- After reset with sw==0: no load, no load_done.

Test Plan:
1. SETTLE_CYCLES=4, MODULUS=60; reset with sw=0, run 20 cycles -> value=0, load_done never asserted, carry never asserted.
2. sw 0->45 sampled at edge E -> value=45 and load_done=1 after edge E+4, load_done=0 after E+5. Repeat with bounce 45->12->45 at E+1,E+2 -> load of 45 lands after edge E+6; 12 never appears on value.
3. sw=63 held, MODULUS=60 -> value=59 after settle; MODULUS=24 instance with sw=30 -> value=23.
4. value=58, hold=0, two ticks -> 59 then 0, carry=1 only in the cycle after the wrap. With hold=1, 10 ticks -> value unchanged, carry=0.
5. value=0, btn_dn press -> 59, carry=0. Then btn_up and btn_dn rising on same edge -> 59. Held btn_up for 10 cycles -> exactly +1. Tick coincident with btn_up edge at value=10 -> 11 (tick dropped). Tick coincident with a load -> loaded value, no carry.
6. sw=45 settling, rst_n pulled low at edge E+2 -> value=0 immediately, before next clk edge. rst_n released with sw=45 held -> value=45 and load_done pulse SETTLE_CYCLES edges after first post-release edge.

Source files
------------

// File: rtl/time_field_counter.sv
// rtl/time_field_counter.sv - modulo clock-field register with switch load, buttons and tick carry
//
// One instance holds one field of the digital clock (seconds, minutes or hours).
// Instances are chained by wiring carry of one field to tick of the next.
//
// Parameters:
//   WIDTH          bit width of sw / value / led
//   MODULUS        field counts 0..MODULUS-1 (legal 2..2**WIDTH)
//   SETTLE_CYCLES  clk edges sw must hold a new value before it is loaded (>=1)
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   tick       one-cycle advance pulse (timebase or previous field's carry)
//   hold       1 = discard tick; buttons and switch load still act
//   sw         switch set value, already synchronised upstream
//   btn_up     debounced level, rising edge steps +1
//   btn_dn     debounced level, rising edge steps -1
//   value      current field value, registered
//   led        combinational copy of value
//   carry      one-cycle pulse after a tick wraps MODULUS-1 -> 0
//   load_done  one-cycle pulse in the first cycle a switch load is visible

module time_field_counter #(
    parameter int WIDTH         = 6,
    parameter int MODULUS       = 60,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             hold,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_up,
    input  logic             btn_dn,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] led,
    output logic             carry,
    output logic             load_done
);

    // Settle counter only needs to reach SETTLE_CYCLES-1.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);

    // Parameter legality is checked at elaboration so a bad field never builds.
    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("time_field_counter: MODULUS must be in 2..2**WIDTH");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("time_field_counter: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] cand;      // last sampled switch value awaiting settle
    logic [CNT_W-1:0] cnt;       // edges sw has matched cand since the change
    logic             armed;     // a load is pending for cand
    logic             up_prev;   // btn_up level on the previous edge
    logic             dn_prev;   // btn_dn level on the previous edge

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic             sw_changed;
    logic             load_fire;
    logic             up_edge;
    logic             dn_edge;
    logic             btn_event;
    logic             tick_fire;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] val_inc;
    logic [WIDTH-1:0] val_dec;
    logic [WIDTH-1:0] load_val;

    always_comb begin
        sw_changed = (sw != cand);
        // A change on the final settle edge restarts the window instead of loading.
        load_fire  = !sw_changed && armed && (cnt == SETTLE_END);

        up_edge    = btn_up && !up_prev;
        dn_edge    = btn_dn && !dn_prev;
        // Simultaneous up/dn still counts as a button event: it blocks the tick
        // even though the two steps cancel and the value stays put.
        btn_event  = up_edge || dn_edge;

        tick_fire  = tick && !hold;

        // Compare before stepping so MODULUS == 2**WIDTH never needs a wider adder.
        at_max     = (value == MAX_VAL);
        at_zero    = (value == '0);
        val_inc    = at_max  ? '0      : value + 1'b1;
        val_dec    = at_zero ? MAX_VAL : value - 1'b1;

        // Out-of-range switch settings saturate rather than wrap.
        load_val   = (cand > MAX_VAL) ? MAX_VAL : cand;
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value     <= '0;
            carry     <= 1'b0;
            load_done <= 1'b0;
            cand      <= '0;
            cnt       <= '0;
            armed     <= 1'b0;
            up_prev   <= 1'b0;
            dn_prev   <= 1'b0;
        end else begin
            up_prev   <= btn_up;
            dn_prev   <= btn_dn;
            carry     <= 1'b0;
            load_done <= 1'b0;

            // Switch settle tracker
            if (sw_changed) begin
                cand  <= sw;
                cnt   <= '0;
                armed <= 1'b1;
            end else if (armed) begin
                if (cnt == SETTLE_END) begin
                    armed <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Value update: load beats buttons beats tick; losers are dropped.
            if (load_fire) begin
                value     <= load_val;
                load_done <= 1'b1;
            end else if (btn_event) begin
                if (up_edge && !dn_edge) begin
                    value <= val_inc;
                end else if (dn_edge && !up_edge) begin
                    value <= val_dec;
                end
            end else if (tick_fire) begin
                value <= val_inc;
                carry <= at_max;
            end
        end
    end

    assign led = value;

endmodule

// File: tb/tb_time_field_counter.sv
// tb/tb_time_field_counter.sv - directed self-checking bench for time_field_counter
module tb_time_field_counter;

    localparam int W  = 6;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tick;
    logic         hold;
    logic [W-1:0] sw;
    logic         btn_up;
    logic         btn_dn;
    logic [W-1:0] value;
    logic [W-1:0] led;
    logic         carry;
    logic         load_done;

    logic [W-1:0] sw_b;
    logic [W-1:0] value_b;
    logic [W-1:0] led_b;
    logic         carry_b;
    logic         load_done_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    time_field_counter #(.WIDTH(W), .MODULUS(60), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .hold(hold), .sw(sw),
        .btn_up(btn_up), .btn_dn(btn_dn), .value(value), .led(led),
        .carry(carry), .load_done(load_done)
    );

    time_field_counter #(.WIDTH(W), .MODULUS(24), .SETTLE_CYCLES(SC)) dut_hr (
        .clk(clk), .rst_n(rst_n), .tick(1'b0), .hold(1'b0), .sw(sw_b),
        .btn_up(1'b0), .btn_dn(1'b0), .value(value_b), .led(led_b),
        .carry(carry_b), .load_done(load_done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle to the sampling point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int pulses;

    initial begin
        rst_n = 1'b0; tick = 1'b0; hold = 1'b0; sw = '0; sw_b = '0;
        btn_up = 1'b0; btn_dn = 1'b0;

        // 1. reset state and idle with sw=0
        steps(2);
        check("rst_value", value, 0);
        check("rst_carry", carry, 0);
        check("rst_load_done", load_done, 0);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (load_done || carry) pulses++;
        end
        check("idle_no_pulses", pulses, 0);
        check("idle_value", value, 0);

        // 2. clean settle 0 -> 45
        sw = 45;
        steps(4);
        check("settle_wait_value", value, 0);
        check("settle_wait_ld", load_done, 0);
        step();
        check("settle_value", value, 45);
        check("settle_ld", load_done, 1);
        check("led_copy", led, 45);
        step();
        check("settle_ld_clear", load_done, 0);

        // back to 0 so the bounce case is observable
        sw = 0;
        steps(6);
        check("reload_zero", value, 0);

        // 2b. bounce 45 -> 12 -> 45, load lands at E+6
        sw = 45; step();           // E
        check("bounce_e0", value, 0);
        sw = 12; step();           // E+1
        check("bounce_e1", value, 0);
        sw = 45;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin   // E+2..E+5
            step();
            if (value != 0 || load_done) pulses++;
        end
        check("bounce_no_early", pulses, 0);
        step();                    // E+6
        check("bounce_value", value, 45);
        check("bounce_ld", load_done, 1);

        // 3. saturating clamp on both moduli
        sw = 63; sw_b = 30;
        steps(5);
        check("clamp60", value, 59);
        check("clamp24", value_b, 23);
        check("clamp24_ld", load_done_b, 1);

        // 4. tick wrap and carry
        sw = 58;
        steps(5);
        check("preset58", value, 58);
        tick = 1'b1; step(); tick = 1'b0;
        check("tick_59", value, 59);
        check("tick_59_carry", carry, 0);
        tick = 1'b1; step(); tick = 1'b0;
        check("tick_wrap", value, 0);
        check("tick_wrap_carry", carry, 1);
        step();
        check("carry_clear", carry, 0);
        hold = 1'b1; tick = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (carry) pulses++;
        end
        tick = 1'b0; hold = 1'b0;
        check("hold_carry", pulses, 0);
        check("hold_value", value, 0);
        step();
        check("hold_not_remembered", value, 0);

        // 5. buttons
        btn_dn = 1'b1; step(); btn_dn = 1'b0;
        check("dn_wrap", value, 59);
        check("dn_carry", carry, 0);
        step();
        btn_up = 1'b1; btn_dn = 1'b1; step();
        check("up_dn_same", value, 59);
        btn_up = 1'b0; btn_dn = 1'b0; step();
        btn_up = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (carry) pulses++;
        end
        btn_up = 1'b0; step();
        check("held_up_once", value, 0);
        check("btn_no_carry", pulses, 0);
        sw = 10;
        steps(5);
        check("preset10", value, 10);
        btn_up = 1'b1; tick = 1'b1; step();
        btn_up = 1'b0; tick = 1'b0;
        check("btn_beats_tick", value, 11);
        step();
        sw = 59;
        steps(5);
        check("preset59", value, 59);
        sw = 5;
        steps(4);
        tick = 1'b1; step(); tick = 1'b0;
        check("load_beats_tick", value, 5);
        check("load_beats_tick_ld", load_done, 1);
        check("load_beats_tick_carry", carry, 0);

        // 6. reset mid-settle
        sw = 45;
        step();                    // E
        step();                    // E+1
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_value", value, 0);
        steps(2);
        rst_n = 1'b1;
        step();                    // first post-release edge F
        check("post_rst_f0", value, 0);
        steps(3);                  // F+3
        check("post_rst_wait", value, 0);
        check("post_rst_wait_ld", load_done, 0);
        step();                    // F+4
        check("post_rst_value", value, 45);
        check("post_rst_ld", load_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
